// File: rtl/core_pkg.sv
// core_pkg: shared types and default constants for the execute-stage
// multiply/divide sequencing controller.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } muldiv_op_t;

    localparam int MUL_LAT_DEF = 2;
    localparam int DIV_LAT_DEF = 33;

endpackage

// File: rtl/muldiv_hazard_ctrl_load_use_detect.sv
// load_use_detect: combinational load-use hazard compare between the load
// sitting in EX and the source registers of the instruction in ID.
module load_use_detect (
    input  logic       memread,
    input  logic [4:0] rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    output logic       hazard
);

    // x0 is hardwired to zero, so a load into it never creates a dependency
    assign hazard = memread && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));

endmodule

// File: rtl/muldiv_hazard_ctrl.sv
// muldiv_hazard_ctrl: issues multiply/divide ops to the multi-cycle units,
// freezes the pipe while they run, pulses ready to forwarding on completion
// and inserts a one-cycle bubble on load-use hazards.
// Optional build macro: MULDIV_DONE_HS_EN -- leave WAIT on the unit's
// mul_done/div_done handshake instead of the latency counter.
//
// state | meaning
// IDLE  | no op in flight; an EX mul/div issues here
// WAIT  | unit running, whole pipe frozen, counter ticking
// DONE  | result valid this cycle, ready pulse, pipe released
module muldiv_hazard_ctrl
    import core_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ex_valid,
    input  logic       ex_mul_req,
    input  logic       ex_div_req,
    input  logic       flush,
    input  logic [4:0] IF_ID_rs1,
    input  logic [4:0] IF_ID_rs2,
    input  logic [4:0] ID_EX_rd,
    input  logic       ID_EX_memread,
    input  logic       mul_done,
    input  logic       div_done,
    output logic       mul_start,
    output logic       div_start,
    output logic       mul_ready,
    output logic       div_ready,
    output logic       stall_if,
    output logic       stall_id,
    output logic       stall_ex,
    output logic       bubble_ex,
    output logic       busy
);

    localparam int CW = $clog2(DIV_LAT + 1);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    muldiv_state_t state;
    muldiv_op_t    op_type;
    logic [CW-1:0] cnt;

    logic issue;
    logic wait_done;
    logic md_stall;
    logic hazard;
    logic lu_stall;

    load_use_detect u_load_use_detect (
        .memread (ID_EX_memread),
        .rd      (ID_EX_rd),
        .rs1     (IF_ID_rs1),
        .rs2     (IF_ID_rs2),
        .hazard  (hazard)
    );

    // Issue only from IDLE; the EX instruction is killed by a concurrent flush
    assign issue = !rst && (state == IDLE) && ex_valid
                   && (ex_mul_req || ex_div_req) && !flush;

`ifdef MULDIV_DONE_HS_EN
    // The unit tells us when it is finished; only the matching unit counts
    assign wait_done = (op_type == OP_MUL) ? mul_done : div_done;
`else
    // Fixed latency: the counter reaching 1 marks the last WAIT cycle
    assign wait_done = (cnt == CNT_ONE);
    logic unused_done;
    assign unused_done = mul_done ^ div_done;
`endif

    // Sequencing FSM, op-type record and latency down-counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_type <= OP_MUL;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        // Multiply wins when both requests are present
                        op_type <= ex_mul_req ? OP_MUL : OP_DIV;
                        cnt     <= ex_mul_req ? MUL_LOAD : DIV_LOAD;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // Saturate at 1 so a late handshake never wraps the count
                    if (cnt > CNT_ONE) begin
                        cnt <= cnt - CNT_ONE;
                    end
                    if (flush) begin
                        state <= IDLE;
                    end else if (wait_done) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Freeze the whole pipe from issue through WAIT; a flush releases it at once
    assign md_stall = issue || (!rst && (state == WAIT) && !flush);

    // Load-use bubble only when the mul/div freeze is not already holding the pipe
    assign lu_stall = !rst && hazard && !md_stall;

    assign mul_start = issue && ex_mul_req;
    assign div_start = issue && !ex_mul_req;

    assign mul_ready = !rst && (state == DONE) && (op_type == OP_MUL) && !flush;
    assign div_ready = !rst && (state == DONE) && (op_type == OP_DIV) && !flush;

    assign stall_if  = md_stall || lu_stall;
    assign stall_id  = md_stall || lu_stall;
    assign stall_ex  = md_stall;
    assign bubble_ex = lu_stall;

    assign busy = !rst && ((state == WAIT) || (state == DONE));

endmodule

// File: doc/muldiv_hazard_ctrl.md
# muldiv_hazard_ctrl

Pipeline sequencing controller for the execute stage. It issues multiply and divide operations to the multi-cycle units and freezes the pipeline while they run. On completion it raises the `mul_ready`/`div_ready` pulses that steer the EX-stage forwarding mux. It also detects load-use hazards and inserts a single bubble, and sits beside the forwarding unit, driving the IF/ID/EX pipeline-register enables.

## Interface
Parameters:
- `MUL_LAT`, 2: multiplier latency in cycles; minimum 2.
- `DIV_LAT`, 33: divider latency in cycles; minimum 2.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-high reset.
- `ex_valid`  in  1  EX stage holds a valid instruction.
- `ex_mul_req`  in  1  EX instruction is a multiply.
- `ex_div_req`  in  1  EX instruction is a divide or remainder.
- `flush`  in  1  branch/trap flush; kills the EX instruction.
- `IF_ID_rs1`, `IF_ID_rs2`  in  5 each  ID-stage source registers.
- `ID_EX_rd`  in  5  EX-stage destination register.
- `ID_EX_memread`  in  1  EX instruction is a load.
- `mul_done`, `div_done`  in  1 each  unit completion; used only with the macro (see Configuration).
- `mul_start`, `div_start`  out  1 each  one-cycle issue pulse to the unit.
- `mul_ready`, `div_ready`  out  1 each  one-cycle result-valid pulse to forwarding.
- `stall_if`, `stall_id`, `stall_ex`  out  1 each  hold the respective pipeline register.
- `bubble_ex`  out  1  load NOP into ID/EX.
- `busy`  out  1  operation in flight.

## Operation
- State machine: `IDLE`, `WAIT`, `DONE`. An op-type register records mul or div.
- Issue condition: `IDLE & ex_valid & (ex_mul_req|ex_div_req) & !flush`.
  - If both requests are set, multiply wins and the divide is ignored.
  - On issue, `*_start` pulses combinationally.
  - The latency counter loads `LAT-1`.
  - The next state is `WAIT`.
- `WAIT`:
  - The counter decrements each cycle.
  - `WAIT -> DONE` when the counter equals 1.
- `DONE`:
  - `mul_ready` or `div_ready` is asserted per the op type, and the stalls are released.
  - The next state is `IDLE`.
- Stall outputs:
  - `stall_if`, `stall_id` and `stall_ex` are all asserted during the issue cycle and throughout `WAIT`.
  - `busy` is set in `WAIT` and `DONE`.
- Flush:
  - A flush in `WAIT` or `DONE` forces `IDLE` on the next cycle.
  - The ready pulse is suppressed, including in the `DONE` cycle itself.
  - Stalls drop in the flush cycle.
- Load-use hazard:
  - Condition: `ID_EX_memread & ID_EX_rd!=0 & (ID_EX_rd==IF_ID_rs1 | ID_EX_rd==IF_ID_rs2)`.
  - Response: `stall_if`, `stall_id` and `bubble_ex` are asserted for one cycle.
- Priority: a multiply/divide stall overrides load-use. The whole pipe is frozen and `bubble_ex` is held at 0.
- Counter width: `$clog2(DIV_LAT+1)` bits, unsigned. The counter never wraps below 1 in `WAIT`.

## Timing
- Reset: state `IDLE`, counter 0, op type mul. All outputs are 0 while `rst` is high.
- Issue at cycle T gives result-ready at T+LAT.
  - Stall is high for cycles T..T+LAT-1.
  - The pipeline advances at T+LAT.
- Back-to-back operations: the next EX instruction is seen at T+LAT+1 in `IDLE`. It can issue in that same cycle, so there are no dead cycles.
- Mid-operation reset: the controller returns asynchronously to `IDLE` and all pulses are dropped.
- Load-use bubble: a one-cycle combinational response. The same instruction pair cannot re-trigger, because the load has advanced.

## Configuration
- `MULDIV_DONE_HS_EN` defined:
  - `WAIT -> DONE` is taken on `mul_done`/`div_done` (matching the op type) instead of the counter.
  - The counter still runs.
  - If `done` arrives in the issue cycle, it is ignored.
- Macro undefined:
  - Fixed-latency counter only.
  - `mul_done` and `div_done` are unused.

## Structure
- Shared package `core_pkg` holds:
  - the state enum `muldiv_state_t`;
  - the op-type enum `muldiv_op_t`;
  - default constants `MUL_LAT_DEF` = 2 and `DIV_LAT_DEF` = 33.
- Sub-module `load_use_detect`: purely combinational hazard compare, producing `hazard`. The FSM and counter stay in the top module.

## Test plan
- Mul, `MUL_LAT`=2, request at T -> `mul_start`@T, stalls@T and T+1, `mul_ready`@T+2, `busy` low @T+3.
- Div, `DIV_LAT`=33 -> stall for exactly 33 cycles, `div_ready` once @T+33; immediate second div at T+34 issues with no gap.
- Load x5 in EX, ID `rs2`=5 -> `stall_if`, `stall_id` and `bubble_ex` high for 1 cycle. With `rd`=0 -> no stall.
- Flush at T+10 of a div -> `IDLE` @T+11, no `div_ready`, stalls drop @T+10.
- `rst` asserted during `WAIT` -> all outputs 0 immediately; a new mul after release behaves as in test 1.
- `ex_mul_req` and `ex_div_req` both high -> `mul_start` only. With `MULDIV_DONE_HS_EN`: `mul_done` at T+5 -> `mul_ready`@T+6.
